// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Decodes the latched
// instruction, steps it through 3-5 states and drives the ALU op code,
// datapath mux selects and write enables. Also counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic [2:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             dec_illegal;
  logic             alu_f3_ok, br_f3_ok, taken, retire;

  // ALU op for arithmetic funct3; sub only applies to R-type with funct7b5
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_dec = sub ? OP_SUB : OP_ADD;
      3'b111:  alu_dec = OP_AND;
      3'b110:  alu_dec = OP_OR;
      3'b100:  alu_dec = OP_XOR;
      3'b010:  alu_dec = OP_SLT;
      3'b011:  alu_dec = OP_SLTU;
      default: alu_dec = OP_ADD;
    endcase
  endfunction

  // Shift funct3 codes are rejected for R/I; branch funct3 01x is undefined
  assign alu_f3_ok = (funct3 != 3'b001) && (funct3 != 3'b101);
  assign br_f3_ok  = (funct3[2:1] != 2'b01);
  // Inverted-sense branches (bne/blt/bltu) are taken on !zero
  assign taken     = (funct3[2] ^ funct3[0]) ? ~zero : zero;
  assign retire    = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                     (state_q == S_LUI);
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

  // Next-state sequencing and illegal-instruction detection in DECODE
  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OPC_LW, OPC_SW: state_d = S_MEMADR;
          OPC_R:    begin state_d = alu_f3_ok ? S_EXEC_R : S_FETCH; dec_illegal = ~alu_f3_ok; end
          OPC_I:    begin state_d = alu_f3_ok ? S_EXEC_I : S_FETCH; dec_illegal = ~alu_f3_ok; end
          OPC_BR:   begin state_d = br_f3_ok ? S_BRANCH : S_FETCH;  dec_illegal = ~br_f3_ok; end
          OPC_JAL:  state_d = S_JAL;
          OPC_JALR: state_d = S_JALR;
          OPC_LUI:  state_d = S_LUI;
          default:  begin state_d = S_FETCH; dec_illegal = 1'b1; end
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Moore outputs per state, forced quiet while reset is held
  always_comb begin
    alu_op     = OP_ADD;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01;
        imm_src   = (op == OPC_JAL) ? 3'b011 : 3'b010;
        illegal   = dec_illegal;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; imm_src = op[5] ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      S_EXEC_R:   begin alu_src_a = 2'b10; alu_op = alu_dec(funct3, funct7b5); end
      S_EXEC_I: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = alu_dec(funct3, 1'b0);
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = (funct3[2:1] == 2'b00) ? OP_SUB : (funct3[1] ? OP_SLTU : OP_SLT);
        pc_write  = taken;
      end
      S_JALR:     begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
      S_LUI:      begin imm_src = 3'b100; result_src = 2'b11; reg_write = 1'b1; end
      default:    ;
    endcase
    if (!rst_n) begin
      alu_op = 3'b000; alu_src_a = 2'b00; alu_src_b = 2'b00; result_src = 2'b00;
      imm_src = 3'b000; adr_src = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
      mem_write = 1'b0; reg_write = 1'b0; illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table with per-cycle expected
// output words queued on a scoreboard, plus reset-abort and counter-wrap runs.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero;

  logic [2:0]  alu_op, alu_op_w;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_src_a_w, alu_src_b_w, result_src_w;
  logic [2:0]  imm_src, imm_src_w;
  logic        adr_src, ir_write, pc_write, mem_write, reg_write, illegal;
  logic        adr_src_w, ir_write_w, pc_write_w, mem_write_w, reg_write_w, illegal_w;
  logic [31:0] instret;
  logic [2:0]  instret_w;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal), .instret(instret));

  multicycle_controller #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .alu_op(alu_op_w), .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w),
    .result_src(result_src_w), .imm_src(imm_src_w), .adr_src(adr_src_w),
    .ir_write(ir_write_w), .pc_write(pc_write_w), .mem_write(mem_write_w),
    .reg_write(reg_write_w), .illegal(illegal_w), .instret(instret_w));

  always #5 clk = ~clk;

  wire [17:0] dut_v = {alu_op, alu_src_a, alu_src_b, result_src, imm_src,
                       adr_src, ir_write, pc_write, mem_write, reg_write, illegal};
  wire [17:0] dut_wv = {alu_op_w, alu_src_a_w, alu_src_b_w, result_src_w, imm_src_w,
                        adr_src_w, ir_write_w, pc_write_w, mem_write_w, reg_write_w, illegal_w};

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       zero;
    logic [2:0] xalu;
    logic       taken;
    logic       ill;
  } vec_t;

  vec_t        vecs[24];
  logic [17:0] sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_instret = 0;

  function automatic logic [17:0] ov(int alu, int a, int b, int rs, int imm,
                                     int adr, int ir, int pcw, int mw, int rw, int ill);
    logic [31:0] t_alu, t_a, t_b, t_rs, t_imm;
    t_alu = alu; t_a = a; t_b = b; t_rs = rs; t_imm = imm;
    return {t_alu[2:0], t_a[1:0], t_b[1:0], t_rs[1:0], t_imm[2:0],
            adr != 0, ir != 0, pcw != 0, mw != 0, rw != 0, ill != 0};
  endfunction

  function automatic vec_t mk(string n, logic [6:0] o, logic [2:0] f, logic f7, logic z,
                              logic [2:0] xa, logic tk, logic il);
    vec_t v;
    v.name = n; v.op = o; v.f3 = f; v.f7b5 = f7; v.zero = z;
    v.xalu = xa; v.taken = tk; v.ill = il;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the expected output word for every cycle of one instruction
  task automatic push_expected(input vec_t v);
    logic [17:0] fetch_v, aluwb_v, jal_v;
    fetch_v = ov(0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0);
    aluwb_v = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    jal_v   = ov(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    sb.push_back(fetch_v);
    sb.push_back(ov(0, 1, 1, 0, (v.op == 7'b1101111) ? 3 : 2, 0, 0, 0, 0, 0, v.ill ? 1 : 0));
    if (!v.ill) begin
      case (v.op)
        7'b0000011: begin
          sb.push_back(ov(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
          sb.push_back(ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
          sb.push_back(ov(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        end
        7'b0100011: begin
          sb.push_back(ov(0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
          sb.push_back(ov(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        end
        7'b0110011: begin
          sb.push_back(ov(v.xalu, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          sb.push_back(aluwb_v);
        end
        7'b0010011: begin
          sb.push_back(ov(v.xalu, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
          sb.push_back(aluwb_v);
        end
        7'b1100011: sb.push_back(ov(v.xalu, 2, 0, 0, 0, 0, 0, v.taken, 0, 0, 0));
        7'b1101111: begin sb.push_back(jal_v); sb.push_back(aluwb_v); end
        7'b1100111: begin
          sb.push_back(ov(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
          sb.push_back(jal_v);
          sb.push_back(aluwb_v);
        end
        default:    sb.push_back(ov(0, 0, 0, 3, 4, 0, 0, 0, 0, 1, 0));
      endcase
    end
  endtask

  // Caller guarantees the next falling edge lies in a FETCH cycle
  task automatic run_vec(input vec_t v);
    logic [17:0] e;
    logic [31:0] ei;
    int n;
    push_expected(v);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        op = v.op; funct3 = v.f3; funct7b5 = v.f7b5; zero = v.zero;
      end
      #1;
      e = sb.pop_front();
      check({v.name, "_outs"}, {14'd0, dut_v}, {14'd0, e});
      check({v.name, "_outs_w"}, {14'd0, dut_wv}, {14'd0, e});
      if (i == 0) begin
        ei = exp_instret;
        check({v.name, "_instret"}, instret, ei);
        check({v.name, "_instret_w"}, {29'd0, instret_w}, {29'd0, ei[2:0]});
      end
    end
    if (!v.ill) exp_instret++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outs", {14'd0, dut_v}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_outs_hold", {14'd0, dut_v}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_instret_w", {29'd0, instret_w}, 32'd0);
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  initial begin
    vecs[0]  = mk("add",    7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[1]  = mk("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    vecs[2]  = mk("and",    7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    vecs[3]  = mk("or",     7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0);
    vecs[4]  = mk("xor",    7'b0110011, 3'b100, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0);
    vecs[5]  = mk("slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    vecs[6]  = mk("sltu",   7'b0110011, 3'b011, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
    vecs[7]  = mk("addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[8]  = mk("sltiu",  7'b0010011, 3'b011, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
    vecs[9]  = mk("blt_t",  7'b1100011, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0);
    vecs[10] = mk("blt_nt", 7'b1100011, 3'b100, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0);
    vecs[11] = mk("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
    vecs[12] = mk("bne_nt", 7'b1100011, 3'b001, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    vecs[13] = mk("bgeu_t", 7'b1100011, 3'b111, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0);
    vecs[14] = mk("bge_nt", 7'b1100011, 3'b101, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    vecs[15] = mk("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[16] = mk("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[17] = mk("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[18] = mk("jalr",   7'b1100111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[19] = mk("lui",    7'b0110111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    vecs[20] = mk("ill_op", 7'b0000000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    vecs[21] = mk("ill_sll",7'b0110011, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    vecs[22] = mk("ill_sri",7'b0010011, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    vecs[23] = mk("ill_br", 7'b1100011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);

    op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 24; i++) run_vec(vecs[i]);

    // Abort a load in MEMREAD: no write-back, counter cleared
    @(negedge clk);
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    #1 check("abort_fetch", {14'd0, dut_v}, {14'd0, ov(0, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0)});
    check("abort_pre_instret", instret, exp_instret);
    @(negedge clk);
    #1 check("abort_decode", {14'd0, dut_v}, {14'd0, ov(0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0)});
    @(negedge clk);
    #1 check("abort_memadr", {14'd0, dut_v}, {14'd0, ov(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0)});
    @(negedge clk);
    #1 check("abort_memread", {14'd0, dut_v}, {14'd0, ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
    apply_reset();
    run_vec(vecs[19]);

    // Small counter instance wraps 7 -> 0 while the wide one keeps counting
    for (int i = 0; i < 8; i++) run_vec(vecs[19]);
    run_vec(vecs[0]);
    @(negedge clk);
    #1 check("final_instret", instret, exp_instret);
    check("final_instret_w", {29'd0, instret_w}, exp_instret & 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
